// File: rtl/img_uart_streamer_if.sv
// BRAM read-port bundle between the image streamer (master) and the pixel BRAM (slave).
interface img_uart_streamer_if #(
  parameter int unsigned ADDR_W = 15
);
  logic              en;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        dout;

  modport master (output en, output we, output addr, input dout);
  modport slave  (input en, input we, input addr, output dout);
endinterface

// File: rtl/img_uart_streamer.sv
// Streams NUM_PIXELS bytes from a BRAM read port over UART 8N1 with gapless back-to-back bytes.
// Optional feature: define IMG_FRAME_HDR_EN to prefix every frame with header bytes 0xA5, 0x5A.
module img_uart_streamer #(
  parameter int unsigned NUM_PIXELS   = 22500,
  parameter int unsigned ADDR_W       = 15,
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter int unsigned READ_LAT     = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                transmit,
  img_uart_streamer_if.master bram,
  output logic                TxD,
  output logic                busy,
  output logic                show_i
);

`ifdef IMG_FRAME_HDR_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  localparam int unsigned   BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] PIX_LAST  = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [1:0]    RD_START  = 2'(READ_LAT + 1);
  localparam logic [7:0]    HDR_BYTE0 = 8'hA5;
  localparam logic [7:0]    HDR_BYTE1 = 8'h5A;

  typedef enum logic [2:0] {
    IDLE,
    PREFETCH,
    START,
    DATA,
    STOP,
    DONE
  } state_t;

  state_t              state, state_n;
  logic [BAUD_W-1:0]   baud, baud_n;
  logic [2:0]          bit_idx, bit_n;
  logic [7:0]          shift, shift_n;
  logic [7:0]          hold, hold_n;
  logic                hold_vld, hold_vld_n;
  logic [ADDR_W-1:0]   pix_cnt, pix_n;
  logic [1:0]          hdr_left, hdr_n;
  logic [1:0]          rd_cnt, rd_cnt_n;
  logic                en_q, en_n;
  logic [ADDR_W-1:0]   addr_q, addr_n;
  logic                txd_n, busy_n, show_n;
  logic                baud_end;

  assign bram.en   = en_q;
  assign bram.we   = 1'b0;
  assign bram.addr = addr_q;
  assign baud_end  = (baud == BAUD_LAST);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      hold     <= '0;
      hold_vld <= 1'b0;
      pix_cnt  <= '0;
      hdr_left <= '0;
      rd_cnt   <= '0;
      en_q     <= 1'b0;
      addr_q   <= '0;
      TxD      <= 1'b1;
      busy     <= 1'b0;
      show_i   <= 1'b0;
    end else begin
      state    <= state_n;
      baud     <= baud_n;
      bit_idx  <= bit_n;
      shift    <= shift_n;
      hold     <= hold_n;
      hold_vld <= hold_vld_n;
      pix_cnt  <= pix_n;
      hdr_left <= hdr_n;
      rd_cnt   <= rd_cnt_n;
      en_q     <= en_n;
      addr_q   <= addr_n;
      TxD      <= txd_n;
      busy     <= busy_n;
      show_i   <= show_n;
    end
  end

  // Next-state and next-output logic; TxD is computed for the cycle the new state occupies
  always_comb begin
    state_n    = state;
    baud_n     = baud;
    bit_n      = bit_idx;
    shift_n    = shift;
    hold_n     = hold;
    hold_vld_n = hold_vld;
    pix_n      = pix_cnt;
    hdr_n      = hdr_left;
    rd_cnt_n   = (rd_cnt != 2'd0) ? rd_cnt - 2'd1 : 2'd0;
    en_n       = 1'b0;
    addr_n     = addr_q;
    txd_n      = TxD;
    busy_n     = busy;
    show_n     = show_i;

    // rd_cnt reaches 1 in the cycle the requested byte is on bram.dout
    if (rd_cnt == 2'd1) begin
      hold_n     = bram.dout;
      hold_vld_n = 1'b1;
    end

    case (state)
      IDLE, DONE: begin
        if (transmit) begin
          state_n    = PREFETCH;
          busy_n     = 1'b1;
          show_n     = 1'b0;
          addr_n     = '0;
          en_n       = 1'b1;
          rd_cnt_n   = RD_START;
          hold_vld_n = 1'b0;
          pix_n      = '0;
          hdr_n      = '0;
          baud_n     = '0;
          bit_n      = '0;
        end
      end

      PREFETCH: begin
        if (hold_vld) begin
          state_n = START;
          txd_n   = 1'b0;
          baud_n  = '0;
          if (HDR_EN) begin
            shift_n = HDR_BYTE0;
            hdr_n   = 2'd2;
          end else begin
            shift_n = hold;
          end
        end
      end

      START: begin
        if (baud_end) begin
          state_n = DATA;
          baud_n  = '0;
          bit_n   = '0;
          txd_n   = shift[0];
        end else begin
          baud_n = baud + BAUD_W'(1);
        end
      end

      DATA: begin
        // Fetch the next pixel early so STOP can chain straight into the next START
        if (baud == '0 && bit_idx == 3'd0 && hdr_left == 2'd0 && pix_cnt != PIX_LAST) begin
          en_n     = 1'b1;
          addr_n   = addr_q + ADDR_W'(1);
          rd_cnt_n = RD_START;
        end
        if (baud_end) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            txd_n   = 1'b1;
          end else begin
            bit_n   = bit_idx + 3'd1;
            shift_n = {1'b0, shift[7:1]};
            txd_n   = shift[1];
          end
        end else begin
          baud_n = baud + BAUD_W'(1);
        end
      end

      STOP: begin
        if (baud_end) begin
          baud_n = '0;
          if (hdr_left == 2'd2) begin
            shift_n = HDR_BYTE1;
            hdr_n   = 2'd1;
            state_n = START;
            txd_n   = 1'b0;
          end else if (hdr_left == 2'd1) begin
            shift_n = hold;
            hdr_n   = 2'd0;
            state_n = START;
            txd_n   = 1'b0;
          end else if (pix_cnt != PIX_LAST) begin
            shift_n = hold;
            pix_n   = pix_cnt + ADDR_W'(1);
            state_n = START;
            txd_n   = 1'b0;
          end else begin
            state_n = DONE;
            busy_n  = 1'b0;
            show_n  = 1'b1;
          end
        end else begin
          baud_n = baud + BAUD_W'(1);
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/img_uart_streamer.md
Name: img_uart_streamer

Overview:
- Parametrised image-transmit engine. Reads NUM_PIXELS bytes sequentially from an external single-port BRAM read port and serialises them over UART 8N1 on TxD.
- Raises show_i once the last stop bit has physically left the pin.
- Generalises the fixed 150x150 BRAM-to-UART transmitter:
  - configurable image size, address width, baud divisor and BRAM read latency;
  - back-to-back byte streaming;
  - restartable frames;
  - a busy indication.
- Sits between the processed-image BRAM and the board UART pin.

Parameters:
- NUM_PIXELS, 22500, bytes per frame (>=1)
- ADDR_W, 15, BRAM address width; 2**ADDR_W >= NUM_PIXELS
- CLKS_PER_BIT, 10417, clk cycles per UART bit (100 MHz / 9600 baud); >=2
- READ_LAT, 1, BRAM read latency in cycles (1 or 2); must be < 9*CLKS_PER_BIT

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- transmit  in  1  start request, level-sampled
- bram_en  out  1  BRAM port enable, asserted only on read cycles
- bram_we  out  1  BRAM write enable, constant 0
- bram_addr  out  ADDR_W  BRAM read address
- bram_dout  in  8  BRAM read data, valid READ_LAT cycles after the bram_en cycle
- TxD  out  1  UART serial output, idle high
- busy  out  1  high from start accept until the final stop bit ends
- show_i  out  1  frame-complete flag

Behaviour:
- One clock domain (clk). Reset is synchronous, active-high, and has priority over everything.
- Reset values: TxD=1, busy=0, show_i=0, bram_en=0, bram_we=0, bram_addr=0; FSM=IDLE; pixel counter=0; baud counter=0; bit index=0.
- FSM states: IDLE, PREFETCH, START, DATA, STOP, DONE.
- IDLE / DONE:
  - transmit=1 sampled on a clk edge starts a frame: busy<=1, show_i<=0, bram_addr<=0, bram_en pulses 1 cycle, go to PREFETCH.
  - transmit held high after DONE restarts immediately; held high during a frame it is ignored.
- PREFETCH:
  - waits READ_LAT cycles, latches bram_dout into the shift register, then goes to START.
  - start latency from transmit sample to TxD falling edge = READ_LAT+2 cycles.
- START: TxD=0 for exactly CLKS_PER_BIT cycles.
- DATA:
  - 8 bits, LSB first, each exactly CLKS_PER_BIT cycles.
  - On the first cycle of DATA, if more pixels remain: bram_addr increments, bram_en pulses, and the next byte is captured into a holding register READ_LAT cycles later (prefetch).
- STOP:
  - TxD=1 for CLKS_PER_BIT cycles.
  - If pixels remain, the holding register loads the shift register and the next START begins on the very next cycle: zero idle cycles between bytes. One byte period is exactly 10*CLKS_PER_BIT cycles.
  - After the last byte's stop bit completes: busy<=0, show_i<=1 in the same cycle, go to DONE.
- Frame duration from the first TxD falling edge to show_i rising = NUM_PIXELS*10*CLKS_PER_BIT cycles.
- bram_addr:
  - never exceeds NUM_PIXELS-1;
  - holds its last value after the frame;
  - resets to 0 only on a new start or on reset.
- show_i stays high in DONE until reset or the next accepted start.
- NUM_PIXELS=1: no prefetch in DATA; DONE directly after the single stop bit.
- Reset mid-byte: TxD returns high on the following edge (truncated byte permitted); show_i=0, busy=0.
- Baud counter counts 0..CLKS_PER_BIT-1. Its width is $clog2(CLKS_PER_BIT); no wrap artefacts.

Optional Feature:
- Macro: IMG_FRAME_HDR_EN.
- Defined:
  - each frame is preceded by two header bytes, 0xA5 then 0x5A, sent back-to-back, before pixel 0;
  - pixel 0 is prefetched during the header;
  - frame duration becomes (NUM_PIXELS+2)*10*CLKS_PER_BIT;
  - show_i timing is otherwise unchanged.
- Not defined: no header bytes; behaviour exactly as above.

Test Plan:
- Reset defaults: assert reset 3 cycles with transmit=1 -> TxD=1, busy=0, show_i=0, bram_en=0, bram_addr=0 throughout.
- Basic frame (NUM_PIXELS=4, CLKS_PER_BIT=4, READ_LAT=1, BRAM=0x55,0x00,0xFF,0x81; transmit pulsed 1 cycle) -> TxD falls 3 cycles later; UART monitor decodes 0x55,0x00,0xFF,0x81 with no idle gaps; show_i rises exactly 160 cycles after the first falling edge; busy falls the same cycle.
- Address sequence: same run -> bram_addr 0,1,2,3; bram_en high for exactly 4 cycles total; bram_we never 1.
- Latency 2 (READ_LAT=2, CLKS_PER_BIT=2) -> correct bytes decoded, still gapless; first start bit 4 cycles after transmit.
- Restart and ignore: transmit held high across the whole frame and after DONE -> mid-frame level ignored; show_i high 1 cycle, then cleared and a second identical frame sent.
- Reset mid-frame during the DATA bit 3 of byte 1 -> TxD=1 next cycle, FSM idle; a subsequent transmit sends a full frame starting at addr 0; with IMG_FRAME_HDR_EN, the decoded stream begins 0xA5,0x5A.
